// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit streaming path.
package uart_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_MEMWAIT = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_LINE    = 3'd5,
    S_FINISH  = 3'd6
  } state_e;

endpackage

// File: rtl/uart_tx_streamer.sv
// Streams a block of bytes from memory into the UART transmitter, prefetching
// the next byte while the current one is on the line.
module uart_tx_streamer
  import uart_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   bytes_sent
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [ADDR_W:0]     sent_q, sent_d;
  logic [ADDR_W:0]     sent_inc;
  logic [7:0]          pf_data_q, pf_data_d;
  logic                pf_full_q, pf_full_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                ack_first_q, ack_first_d;
  logic [MEM_LAT-1:0]  rd_pipe_q, rd_pipe_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    remain_d    = remain_q;
    sent_d      = sent_q;
    pf_data_d   = pf_data_q;
    pf_full_d   = pf_full_q;
    tx_data_d   = tx_data_q;
    ack_first_d = 1'b0;
    mem_rd      = 1'b0;
    tx_wr       = 1'b0;
    sent_inc    = sent_q + (ADDR_W+1)'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          addr_d    = base_addr;
          len_d     = length;
          remain_d  = length;
          sent_d    = '0;
          pf_full_d = 1'b0;
          state_d   = (length == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        state_d = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        if (pf_full_q && !tx_busy) state_d = S_SEND;
      end
      S_SEND: begin
        tx_wr       = 1'b1;
        ack_first_d = 1'b1;
        state_d     = S_ACK;
      end
      S_ACK: begin
        // Prefetch the next byte while this one is being shifted out.
        if (ack_first_q && remain_q != '0) mem_rd = 1'b1;
        if (tx_busy) state_d = S_LINE;
      end
      S_LINE: begin
        if (!tx_busy) begin
          sent_d = sent_inc;
          if (sent_inc == len_q) state_d = S_FINISH;
          else if (pf_full_q)    state_d = S_SEND;
          else                   state_d = S_MEMWAIT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (mem_rd) begin
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - (ADDR_W+1)'(1);
    end

    if (rd_pipe_q[MEM_LAT-1]) begin
      pf_data_d = mem_dout;
      pf_full_d = 1'b1;
    end

    // Load tx_data on entry to SEND so it is already valid alongside tx_wr.
    if (state_d == S_SEND && state_q != S_SEND) begin
      tx_data_d = pf_data_q;
      pf_full_d = 1'b0;
    end

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      mem_rd    = 1'b0;
      tx_wr     = 1'b0;
      pf_full_d = 1'b0;
    end

    // Reads still in flight are dropped whenever the stream ends.
    rd_pipe_d = (state_d == S_IDLE) ? '0 : ((rd_pipe_q << 1) | MEM_LAT'(mem_rd));
  end

  always_ff @(posedge clk_50m) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      remain_q    <= '0;
      sent_q      <= '0;
      // NOTE: the prefetch data register is reset too; it is a single byte, not a memory array.
      pf_data_q   <= '0;
      pf_full_q   <= 1'b0;
      tx_data_q   <= '0;
      ack_first_q <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      remain_q    <= remain_d;
      sent_q      <= sent_d;
      pf_data_q   <= pf_data_d;
      pf_full_q   <= pf_full_d;
      tx_data_q   <= tx_data_d;
      ack_first_q <= ack_first_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign mem_addr   = addr_q;
  assign tx_data    = tx_data_q;
  assign bytes_sent = sent_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done       = (state_q == S_FINISH);

endmodule
